// File: rtl/bitstream_decoder_array_if.sv
// Result stream of bitstream_decoder_array: valid/ready handshake plus per-lane decoded values.
// Lane width follows BSDEC_BIPOLAR_EN (RWID+2 bits when defined, RWID+1 otherwise).
interface bitstream_decoder_array_if #(
   parameter int RWID  = 10,
   parameter int LANES = 2
);
`ifdef BSDEC_BIPOLAR_EN
   localparam int OW = RWID + 2;
`else
   localparam int OW = RWID + 1;
`endif

   logic                  outValid;
   logic                  outReady;
   logic [LANES*OW-1:0]   binOut;

   modport master (
      output outValid,
      output binOut,
      input  outReady
   );

   modport slave (
      input  outValid,
      input  binOut,
      output outReady
   );
endinterface

// File: rtl/bitstream_decoder_array.sv
// Multi-lane unary bitstream decoder: counts ones over a 2^RWID enabled-cycle window per lane.
// Macro BSDEC_BIPOLAR_EN selects two's-complement 2*count-2^RWID output instead of the raw count.
module bitstream_decoder_array #(
   parameter int RWID  = 10,
   parameter int LANES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    start,
   input  logic [LANES-1:0]        bsIn,
   output logic                    busy,
   output logic                    overrun,
   bitstream_decoder_array_if.master res
);
`ifdef BSDEC_BIPOLAR_EN
   localparam int OW = RWID + 2;
   localparam logic [OW-1:0] BIAS = {2'b01, {RWID{1'b0}}};
`else
   localparam int OW = RWID + 1;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                state;
   logic [RWID-1:0]       cnt;
   logic [RWID:0]         acc      [LANES];
   logic [RWID:0]         acc_next [LANES];
   logic [LANES*OW-1:0]   enc_next;
   logic [LANES*OW-1:0]   result;
   logic                  valid_q;
   logic                  busy_q;
   logic                  overrun_q;

   // Encoding happens before the result register so reset can force binOut to 0 in either mode.
   always_comb begin
      enc_next = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         acc_next[i] = acc[i] + {{RWID{1'b0}}, bsIn[i]};
`ifdef BSDEC_BIPOLAR_EN
         enc_next[i*OW +: OW] = {acc_next[i], 1'b0} - BIAS;
`else
         enc_next[i*OW +: OW] = acc_next[i];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         result    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ACCUM;
                  for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
               end
            end
            ACCUM: begin
               if (enable) begin
                  cnt <= cnt + 1'b1;
                  for (int unsigned i = 0; i < LANES; i++) acc[i] <= acc_next[i];
                  if (cnt == '1) begin
                     result  <= enc_next;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               if (res.outReady) begin
                  valid_q <= 1'b0;
                  if (start) begin
                     cnt    <= '0;
                     busy_q <= 1'b1;
                     state  <= ACCUM;
                     for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (start) begin
                  overrun_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign res.outValid = valid_q;
   assign res.binOut   = result;
endmodule

// File: tb/tb_bitstream_decoder_array.sv
// Directed bench for bitstream_decoder_array at RWID=4, LANES=2; expectations follow BSDEC_BIPOLAR_EN.
module tb_bitstream_decoder_array;
`ifdef BSDEC_BIPOLAR_EN
   localparam int OW = 6;
`else
   localparam int OW = 5;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  bsIn = 2'b00;
   logic        busy;
   logic        overrun;
   int          total = 0;
   int          bad = 0;

   bitstream_decoder_array_if #(.RWID(4), .LANES(2)) res ();

   bitstream_decoder_array #(.RWID(4), .LANES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .start   (start),
      .bsIn    (bsIn),
      .busy    (busy),
      .overrun (overrun),
      .res     (res.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [OW-1:0] enc(input int c);
`ifdef BSDEC_BIPOLAR_EN
      return OW'(2 * c - 16);
`else
      return OW'(c);
`endif
   endfunction

   function automatic logic [31:0] pair(input int l1, input int l0);
      logic [2*OW-1:0] v;
      v = {enc(l1), enc(l0)};
      return 32'(v);
   endfunction

   // Starts a window (optionally as a DONE-state accept+start) and feeds patterns until outValid.
   task automatic run_window(input logic [15:0] p0, input logic [15:0] p1, input int stall_at,
                             input int stall_len, input logic with_ready, output int lat);
      logic [3:0] k;
      int s;
      k = 4'd0;
      s = 0;
      start = 1'b1;
      enable = 1'b1;
      bsIn = 2'b00;
      res.outReady = with_ready;
      tick();
      start = 1'b0;
      res.outReady = 1'b0;
      lat = 1;
      while (!res.outValid && lat < 200) begin
         if (int'(k) == stall_at && s < stall_len) begin
            enable = 1'b0;
            bsIn = 2'b11;
            s++;
         end else begin
            enable = 1'b1;
            bsIn = {p1[k], p0[k]};
            k = k + 4'd1;
         end
         tick();
         lat++;
      end
      enable = 1'b1;
      bsIn = 2'b00;
   endtask

   task automatic accept();
      res.outReady = 1'b1;
      tick();
      res.outReady = 1'b0;
   endtask

   initial begin
      int lat;
      int seen;
      logic [31:0] held;
      res.outReady = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(res.outValid), 32'd0);
      check("rst_bin", 32'(res.binOut), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);

      // Basic window: lane0 all ones, lane1 alternating
      run_window(16'hFFFF, 16'h5555, -1, 0, 1'b0, lat);
      check("lat_basic", 32'(lat), 32'd17);
      check("bin_basic", 32'(res.binOut), pair(8, 16));
      check("busy_done", 32'(busy), 32'd0);
      accept();
      check("acc_valid", 32'(res.outValid), 32'd0);
      check("acc_idle", 32'(busy), 32'd0);

      // Five-cycle stall mid-window with garbage on bsIn
      run_window(16'hFFFF, 16'h5555, 7, 5, 1'b0, lat);
      check("lat_stall", 32'(lat), 32'd22);
      check("bin_stall", 32'(res.binOut), pair(8, 16));
      accept();

      // Consumer back-pressure, then start without accept -> overrun
      run_window(16'h0007, 16'hFFFE, -1, 0, 1'b0, lat);
      check("lat_bp", 32'(lat), 32'd17);
      held = 32'(res.binOut);
      check("bin_bp", held, pair(15, 3));
      repeat (10) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_valid", 32'(res.outValid), 32'd1);
      check("ovr_busy", 32'(busy), 32'd0);
      check("ovr_hold", 32'(res.binOut), held);
      accept();
      check("ovr_acc_v", 32'(res.outValid), 32'd0);
      tick();
      check("ovr_no_win", 32'(busy), 32'd0);

      // Accept and start in the same DONE cycle
      run_window(16'hFFFF, 16'h0000, -1, 0, 1'b0, lat);
      check("bin_b2b0", 32'(res.binOut), pair(0, 16));
      run_window(16'h0000, 16'h0000, -1, 0, 1'b1, lat);
      check("lat_b2b", 32'(lat), 32'd17);
      check("bin_zero", 32'(res.binOut), pair(0, 0));
      check("ovr_sticky", 32'(overrun), 32'd1);
      accept();

      // Reset at cycle 8 of ACCUM
      start = 1'b1;
      tick();
      start = 1'b0;
      enable = 1'b1;
      bsIn = 2'b11;
      repeat (8) tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_valid", 32'(res.outValid), 32'd0);
      check("mr_bin", 32'(res.binOut), 32'd0);
      check("mr_ovr", 32'(overrun), 32'd0);
      seen = 0;
      repeat (25) begin
         tick();
         if (res.outValid || busy) seen++;
      end
      check("mr_quiet", 32'(seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bitstream_decoder_array.md
BITSTREAM_DECODER_ARRAY -- requirements
Module: bitstream_decoder_array

Interface
REQ-001 SHALL have parameter RWID, default 10, the window exponent; the window length is 2^RWID enabled cycles.
REQ-002 SHALL have parameter LANES, default 2, the number of independent bitstream lanes.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, the stall control; it qualifies accumulation in lockstep with the shared RNG enable.
REQ-007 SHALL have port start, input, 1, which requests a new decode window.
REQ-008 SHALL have port bsIn, input, LANES, the unary bitstream bits, one per lane.
REQ-009 SHALL have port busy, output, 1, which is high while in ACCUM.
REQ-010 SHALL have port outValid, output, 1, which is high when results are held.
REQ-011 SHALL have port outReady, input, 1, the consumer accept signal.
REQ-012 SHALL have port binOut, output, LANES x (RWID+1), the decoded value per lane.
REQ-013 SHALL have port overrun, output, 1, a sticky flag set when start arrives while results are unaccepted.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-015 IDLE: on start=1, SHALL clear the cycle counter and all lane accumulators and enter ACCUM on the next cycle.
REQ-016 ACCUM: on each cycle with enable=1, SHALL increment the cycle counter (RWID bits) and add bsIn[i] to acc[i] (RWID+1 bits, no saturation needed).
REQ-017 ACCUM: on a cycle with enable=0, SHALL hold the counter and accumulators and ignore bsIn.
REQ-018 ACCUM: when the cycle counter equals 2^RWID-1 and enable=1, SHALL write acc[i]+bsIn[i] into the result register, set outValid on the next cycle, and enter DONE.
REQ-019 ACCUM: SHALL ignore start.
REQ-020 DONE: SHALL hold outValid=1 and binOut stable until outValid and outReady are both 1.
REQ-021 DONE: on accept, SHALL enter IDLE, or SHALL enter ACCUM with cleared counters if start=1 in the same cycle.
REQ-022 DONE: start without accept SHALL set overrun and SHALL be otherwise ignored.
REQ-023 The decode latency from start to outValid SHALL be 2^RWID+1 cycles when enable is held high.
REQ-024 The range of binOut SHALL be 0 to 2^RWID inclusive; all-ones input SHALL yield exactly 2^RWID.
REQ-025 Lanes SHALL be fully independent, with identical timing.

Reset
REQ-026 rst=1 SHALL force IDLE, clear the counter, accumulators, result register and overrun, and drive busy=0, outValid=0 and binOut=0.
REQ-027 Reset mid-ACCUM or mid-DONE SHALL discard all partial or held results; no outValid follows.
REQ-028 Reset SHALL take priority over start, enable and outReady.

Configuration
REQ-029 The macro BSDEC_BIPOLAR_EN SHALL select the output encoding.
REQ-030 With BSDEC_BIPOLAR_EN defined, binOut SHALL be two's-complement 2*count - 2^RWID, in RWID+2 bits per lane, range -2^RWID to +2^RWID.
REQ-031 Without BSDEC_BIPOLAR_EN, binOut SHALL be the unsigned count in RWID+1 bits per lane.

Verification (RWID=4, LANES=2)
REQ-032 Start, enable=1, lane0 all ones, lane1 alternating 1/0 -> outValid 17 cycles after start; binOut = {8, 16} (unipolar) or {0, +16} (bipolar).
REQ-033 Same stimulus with enable low for 5 cycles mid-window -> outValid delayed by exactly 5 cycles; values unchanged.
REQ-034 outReady held low for 10 cycles in DONE, then a start pulse -> binOut stable, overrun=1, no new window; on outReady=1 -> IDLE.
REQ-035 outReady=1 and start=1 in the same DONE cycle -> immediate new ACCUM; next outValid 17 cycles later.
REQ-036 rst at cycle 8 of ACCUM -> all outputs 0 next cycle, state IDLE, no outValid produced.
REQ-037 All-zero input -> binOut 0 (unipolar) or -16 (bipolar).
